shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 151 +++++++++++++++
 tb/tb_shift_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
`timescale 1ns/1ps
// shift_sequencer: controller for an external N-bit universal shift register.
// Runs TX (serialise MSB first), RX (deserialise), ROT (rotate left) and
// ASR (arithmetic shift right) operations by sequencing the register's mode
// select and parallel load data. Register clear is never driven from here.
//
// Ports:
//   Clock    rising-edge clock
//   Clear    synchronous active-high reset
//   Start    operation request, sampled only in IDLE
//   Op       0 TX, 1 RX, 2 ROT, 3 ASR
//   Count    shift count for ROT/ASR (clamped to N)
//   DataIn   parallel operand, captured with Start
//   SerIn    serial receive bit (RX)
//   Q        current register contents
//   S        register mode: 0 hold, 1 load, 3 shl, 5 rol, 6 asr
//   D        register parallel load data (latched operand)
//   MSBIn    register MSB serial input (tied low)
//   LSBIn    register LSB serial input (SerIn during RX shifting)
//   SerOut   serial transmit bit, idle high
//   Busy     operation in progress
//   Done     one-cycle completion pulse
//   DataOut  result, held until the next completion
module shift_sequencer #(
  parameter int unsigned N = 8
) (
  input  logic                 Clock,
  input  logic                 Clear,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [$clog2(N):0]   Count,
  input  logic [N-1:0]         DataIn,
  input  logic                 SerIn,
  input  logic [N-1:0]         Q,
  output logic [$clog2(N)-1:0] S,
  output logic [N-1:0]         D,
  output logic                 MSBIn,
  output logic                 LSBIn,
  output logic                 SerOut,
  output logic                 Busy,
  output logic                 Done,
  output logic [N-1:0]         DataOut
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned SW = $clog2(N);

  localparam logic [1:0] OP_TX  = 2'd0;
  localparam logic [1:0] OP_RX  = 2'd1;
  localparam logic [1:0] OP_ROT = 2'd2;
  localparam logic [1:0] OP_ASR = 2'd3;

  localparam logic [SW-1:0] S_HOLD = SW'(0);
  localparam logic [SW-1:0] S_LOAD = SW'(1);
  localparam logic [SW-1:0] S_SHL  = SW'(3);
  localparam logic [SW-1:0] S_ROL  = SW'(5);
  localparam logic [SW-1:0] S_ASR  = SW'(6);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic [N-1:0]  data_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] k_c;

  // Shift count for the requested operation; serial ops always move N bits.
  always_comb begin
    k_c = Count;
    if (Op == OP_TX || Op == OP_RX) begin
      k_c = CW'(N);
    end else if (Count > CW'(N)) begin
      k_c = CW'(N);
    end
  end

  // Sequencer state, operand latch, down-counter and registered results.
  // The counter is loaded with K at acceptance and counts down through SHIFT.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state   <= IDLE;
      op_q    <= OP_TX;
      data_q  <= '0;
      cnt_q   <= '0;
      Done    <= 1'b0;
      DataOut <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_q   <= Op;
            data_q <= (Op == OP_RX) ? '0 : DataIn;
            cnt_q  <= k_c;
            state  <= LOAD;
          end
        end
        LOAD: begin
          state <= (cnt_q != '0) ? SHIFT : DONE;
        end
        SHIFT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          DataOut <= Q;
          Done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register control decode from the current state and latched operation.
  always_comb begin
    S      = S_HOLD;
    SerOut = 1'b1;
    LSBIn  = 1'b0;
    case (state)
      LOAD: S = S_LOAD;
      SHIFT: begin
        case (op_q)
          OP_TX: begin
            S      = S_SHL;
            SerOut = Q[N-1];
          end
          OP_RX: begin
            S     = S_SHL;
            LSBIn = SerIn;
          end
          OP_ROT:  S = S_ROL;
          default: S = S_ASR;
        endcase
      end
      default: S = S_HOLD;
    endcase
  end

  assign D     = data_q;
  assign MSBIn = 1'b0;
  assign Busy  = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
`timescale 1ns/1ps
// Directed bench for shift_sequencer with N=8 and a behavioural universal
// shift register closing the loop between S/D/LSBIn and Q.
module tb_shift_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 3;

  logic          Clock = 1'b0;
  logic          Clear;
  logic          Start;
  logic [1:0]    Op;
  logic [CW-1:0] Count;
  logic [N-1:0]  DataIn;
  logic          SerIn;
  logic [N-1:0]  Q;
  logic [SW-1:0] S;
  logic [N-1:0]  D;
  logic          MSBIn;
  logic          LSBIn;
  logic          SerOut;
  logic          Busy;
  logic          Done;
  logic [N-1:0]  DataOut;

  logic rclr;
  int   errors = 0;
  int   checks = 0;

  shift_sequencer #(.N(N)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .Op(Op), .Count(Count),
    .DataIn(DataIn), .SerIn(SerIn), .Q(Q), .S(S), .D(D), .MSBIn(MSBIn),
    .LSBIn(LSBIn), .SerOut(SerOut), .Busy(Busy), .Done(Done), .DataOut(DataOut)
  );

  always #5 Clock = ~Clock;

  // Controlled universal shift register.
  always @(posedge Clock) begin
    if (rclr) Q <= '0;
    else begin
      case (S)
        3'd1:    Q <= D;
        3'd3:    Q <= {Q[N-2:0], LSBIn};
        3'd5:    Q <= {Q[N-2:0], Q[N-1]};
        3'd6:    Q <= {Q[N-1], Q[N-1:1]};
        default: Q <= Q;
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Request an operation at the next edge (edge 0); returns in cycle 1 with
  // Op/Count scrambled so any late re-sampling would be visible.
  task automatic issue(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [N-1:0] din);
    @(negedge Clock);
    Start = 1'b1; Op = op; Count = cnt; DataIn = din;
    @(posedge Clock);
    #1;
    Start = 1'b0; Op = op ^ 2'b11; Count = '1; DataIn = ~din;
  endtask

  task automatic test_reset;
    Clear = 1'b1; Start = 1'b1; Op = 2'd2; Count = 4'd1; DataIn = 8'hFF; SerIn = 1'b1; rclr = 1'b1;
    tick; tick;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL reset_dataout: got %h expected 00", DataOut); end
    checks++; if (S !== 3'd0) begin errors++; $display("FAIL reset_s: got %0d expected 0", S); end
    checks++; if (SerOut !== 1'b1) begin errors++; $display("FAIL reset_serout: got %b expected 1", SerOut); end
    checks++; if (D !== 8'h00) begin errors++; $display("FAIL reset_d: got %h expected 00", D); end
    checks++; if (MSBIn !== 1'b0) begin errors++; $display("FAIL reset_msbin: got %b expected 0", MSBIn); end
    checks++; if (LSBIn !== 1'b0) begin errors++; $display("FAIL reset_lsbin: got %b expected 0", LSBIn); end
    Clear = 1'b0; Start = 1'b0; rclr = 1'b0; SerIn = 1'b0;
    tick;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after: got %b expected 0", Busy); end
  endtask

  task automatic test_tx;
    logic [N-1:0] got;
    got = '0;
    issue(2'd0, 4'd0, 8'hA5);
    checks++; if (S !== 3'd1) begin errors++; $display("FAIL tx_load_s: got %0d expected 1", S); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL tx_load_busy: got %b expected 1", Busy); end
    checks++; if (D !== 8'hA5) begin errors++; $display("FAIL tx_load_d: got %h expected a5", D); end
    for (int c = 2; c <= 9; c++) begin
      tick;
      Start = 1'b0;
      got = {got[N-2:0], SerOut};
      checks++; if (S !== 3'd3) begin errors++; $display("FAIL tx_shift_s: cycle %0d got %0d expected 3", c, S); end
      if (c == 5) begin
        checks++; if (D !== 8'hA5) begin errors++; $display("FAIL tx_no_relatch: got %h expected a5", D); end
      end
      if (c == 4) begin
        Start = 1'b1; DataIn = 8'h3C; Op = 2'd2;
      end
    end
    checks++; if (got !== 8'hA5) begin errors++; $display("FAIL tx_serial_bits: got %b expected 10100101", got); end
    tick;
    checks++; if (S !== 3'd0) begin errors++; $display("FAIL tx_done_s: got %0d expected 0", S); end
    checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL tx_done_state: busy %b done %b expected 1 0", Busy, Done); end
    checks++; if (SerOut !== 1'b1) begin errors++; $display("FAIL tx_idle_line: got %b expected 1", SerOut); end
    tick;
    checks++; if (Done !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL tx_done_pulse: done %b busy %b expected 1 0", Done, Busy); end
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL tx_dataout: got %h expected 00", DataOut); end
    tick;
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL tx_done_one_cycle: got %b expected 0", Done); end
  endtask

  task automatic test_rx;
    logic [N-1:0] sbits;
    logic         b;
    sbits = 8'b1100_1010;
    issue(2'd1, 4'd0, 8'hFF);
    checks++; if (D !== 8'h00) begin errors++; $display("FAIL rx_load_d: got %h expected 00", D); end
    checks++; if (S !== 3'd1) begin errors++; $display("FAIL rx_load_s: got %0d expected 1", S); end
    for (int c = 2; c <= 9; c++) begin
      tick;
      b = sbits[9 - c];
      SerIn = b;
      #1;
      checks++; if (LSBIn !== b || S !== 3'd3) begin errors++; $display("FAIL rx_shift: cycle %0d lsbin %b s %0d expected %b 3", c, LSBIn, S, b); end
      checks++; if (SerOut !== 1'b1) begin errors++; $display("FAIL rx_serout: cycle %0d got %b expected 1", c, SerOut); end
    end
    tick;
    SerIn = 1'b1;
    #1;
    checks++; if (LSBIn !== 1'b0) begin errors++; $display("FAIL rx_lsbin_done: got %b expected 0", LSBIn); end
    tick;
    SerIn = 1'b0;
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL rx_done: got %b expected 1", Done); end
    checks++; if (DataOut !== 8'hCA) begin errors++; $display("FAIL rx_dataout: got %h expected ca", DataOut); end
  endtask

  task automatic test_rot;
    int done_cyc;
    int nshift;
    issue(2'd2, 4'd1, 8'h81);
    checks++; if (S !== 3'd1) begin errors++; $display("FAIL rot1_load_s: got %0d expected 1", S); end
    tick;
    checks++; if (S !== 3'd5) begin errors++; $display("FAIL rot1_shift_s: got %0d expected 5", S); end
    tick;
    checks++; if (S !== 3'd0 || Busy !== 1'b1) begin errors++; $display("FAIL rot1_done_state: s %0d busy %b expected 0 1", S, Busy); end
    tick;
    checks++; if (Done !== 1'b1 || DataOut !== 8'h03) begin errors++; $display("FAIL rot1_result: done %b data %h expected 1 03", Done, DataOut); end
    issue(2'd2, 4'd12, 8'h81);
    done_cyc = 0; nshift = 0;
    for (int c = 1; c <= 14; c++) begin
      if (Done === 1'b1 && done_cyc == 0) done_cyc = c;
      if (S === 3'd5) nshift++;
      tick;
    end
    checks++; if (done_cyc != 11) begin errors++; $display("FAIL rot12_done_cycle: got %0d expected 11", done_cyc); end
    checks++; if (nshift != 8) begin errors++; $display("FAIL rot12_shift_cycles: got %0d expected 8", nshift); end
    checks++; if (DataOut !== 8'h81) begin errors++; $display("FAIL rot12_result: got %h expected 81", DataOut); end
  endtask

  task automatic test_asr;
    int done_cyc;
    int nshift;
    issue(2'd3, 4'd3, 8'h80);
    done_cyc = 0; nshift = 0;
    for (int c = 1; c <= 7; c++) begin
      if (Done === 1'b1 && done_cyc == 0) done_cyc = c;
      if (S === 3'd6) nshift++;
      tick;
    end
    checks++; if (done_cyc != 6 || nshift != 3) begin errors++; $display("FAIL asr3_timing: done cycle %0d shifts %0d expected 6 3", done_cyc, nshift); end
    checks++; if (DataOut !== 8'hF0) begin errors++; $display("FAIL asr3_result: got %h expected f0", DataOut); end
    issue(2'd3, 4'd0, 8'h80);
    done_cyc = 0; nshift = 0;
    for (int c = 1; c <= 4; c++) begin
      if (Done === 1'b1 && done_cyc == 0) done_cyc = c;
      if (S === 3'd6) nshift++;
      tick;
    end
    checks++; if (done_cyc != 3 || nshift != 0) begin errors++; $display("FAIL asr0_timing: done cycle %0d shifts %0d expected 3 0", done_cyc, nshift); end
    checks++; if (DataOut !== 8'h80) begin errors++; $display("FAIL asr0_result: got %h expected 80", DataOut); end
  endtask

  task automatic test_clear_abort;
    logic seen_done;
    issue(2'd0, 4'd0, 8'h5A);
    tick; tick; tick; tick;
    Clear = 1'b1;
    tick;
    Clear = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", Busy); end
    checks++; if (S !== 3'd0 || SerOut !== 1'b1) begin errors++; $display("FAIL abort_outputs: s %0d serout %b expected 0 1", S, SerOut); end
    checks++; if (D !== 8'h00 || DataOut !== 8'h00) begin errors++; $display("FAIL abort_data: d %h dataout %h expected 00 00", D, DataOut); end
    seen_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (Done !== 1'b0) seen_done = 1'b1;
      tick;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", seen_done); end
    issue(2'd2, 4'd1, 8'h81);
    tick; tick; tick;
    checks++; if (Done !== 1'b1 || DataOut !== 8'h03) begin errors++; $display("FAIL abort_restart: done %b data %h expected 1 03", Done, DataOut); end
  endtask

  task automatic test_back_to_back;
    @(negedge Clock);
    Start = 1'b1; Op = 2'd3; Count = 4'd0; DataIn = 8'h80;
    tick;
    DataIn = 8'h40;
    checks++; if (D !== 8'h80 || S !== 3'd1) begin errors++; $display("FAIL b2b_first_load: d %h s %0d expected 80 1", D, S); end
    tick;
    checks++; if (D !== 8'h80 || Busy !== 1'b1 || S !== 3'd0) begin errors++; $display("FAIL b2b_first_done: d %h busy %b s %0d expected 80 1 0", D, Busy, S); end
    tick;
    checks++; if (Done !== 1'b1 || Busy !== 1'b0 || DataOut !== 8'h80) begin errors++; $display("FAIL b2b_first_result: done %b busy %b data %h expected 1 0 80", Done, Busy, DataOut); end
    tick;
    checks++; if (Busy !== 1'b1 || S !== 3'd1 || D !== 8'h40) begin errors++; $display("FAIL b2b_second_load: busy %b s %0d d %h expected 1 1 40", Busy, S, D); end
    tick;
    checks++; if (Busy !== 1'b1 || S !== 3'd0) begin errors++; $display("FAIL b2b_start_ignored: busy %b s %0d expected 1 0", Busy, S); end
    tick;
    checks++; if (Done !== 1'b1 || Busy !== 1'b0 || DataOut !== 8'h40) begin errors++; $display("FAIL b2b_second_result: done %b busy %b data %h expected 1 0 40", Done, Busy, DataOut); end
    tick;
    Start = 1'b0;
    checks++; if (Busy !== 1'b1 || S !== 3'd1) begin errors++; $display("FAIL b2b_third_accept: busy %b s %0d expected 1 1", Busy, S); end
    tick; tick;
    checks++; if (Done !== 1'b1 || DataOut !== 8'h40) begin errors++; $display("FAIL b2b_third_result: done %b data %h expected 1 40", Done, DataOut); end
    tick;
  endtask

  initial begin
    test_reset;
    test_tx;
    test_rx;
    test_rot;
    test_asr;
    test_clear_abort;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
